// File: rtl/rr_priority_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the rotating-priority arbiter.
package arb_pkg;

    localparam int unsigned ARB_N        = 8;
    localparam int unsigned ARB_IDW      = 3;
    localparam int unsigned ARB_MAX_HOLD = 16;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    function automatic logic [ARB_N-1:0] arb_onehot(input logic [ARB_IDW-1:0] idx);
        arb_onehot      = '0;
        arb_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requester blocks (master) and the arbiter (slave).
interface rr_priority_arbiter_if #(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = 3
);
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           timeout;

    modport master (
        output req, done,
        input  grant, grant_id, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_id, grant_valid, timeout
    );
endinterface

// File: rtl/rr_priority_arbiter_prio_enc.sv
// Highest-index-first priority encoder; idx is 0 when no input bit is set.
module prio_enc_n #(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = 3
) (
    input  logic [N-1:0]   in,
    output logic [IDW-1:0] idx,
    output logic           any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int unsigned k = 0; k < N; k++) begin
            if (in[k]) begin
                idx = IDW'(k);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_priority_arbiter.sv
// Rotating-priority arbiter with hold timeout and a mandatory dead cycle between owners.
module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N        = ARB_N,
    parameter int unsigned IDW      = ARB_IDW,
    parameter int unsigned MAX_HOLD = ARB_MAX_HOLD
) (
    input logic               clk,
    input logic               rst_n,
    rr_priority_arbiter_if.slave bus
);
    localparam int unsigned HCW = 8;

    arb_state_t     r_state;
    logic [N-1:0]   r_grant;
    logic [IDW-1:0] r_grant_id;
    logic           r_grant_valid;
    logic           r_timeout;
    logic [IDW-1:0] r_last_id;
    logic [HCW-1:0] r_hold_cnt;

    logic [N-1:0]   w_mask;
    logic [N-1:0]   w_masked;
    logic [IDW-1:0] w_idx_masked;
    logic [IDW-1:0] w_idx_raw;
    logic           w_any_masked;
    logic           w_any_raw;
    logic [IDW-1:0] w_win;
    logic [N-1:0]   w_onehot;
    logic           w_req_own;
    logic           w_expire;

    // Only indices strictly below the last owner survive the mask.
    assign w_mask   = (N'(1) << r_last_id) - N'(1);
    assign w_masked = bus.req & w_mask;

    prio_enc_n #(.N(N), .IDW(IDW)) u_enc_masked (
        .in  (w_masked),
        .idx (w_idx_masked),
        .any (w_any_masked)
    );

    prio_enc_n #(.N(N), .IDW(IDW)) u_enc_raw (
        .in  (bus.req),
        .idx (w_idx_raw),
        .any (w_any_raw)
    );

    assign w_win     = w_any_masked ? w_idx_masked : w_idx_raw;
    assign w_onehot  = N'(1) << w_win;
    assign w_req_own = bus.req[r_grant_id];
    assign w_expire  = (r_hold_cnt == HCW'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_last_id     <= '0;
            r_hold_cnt    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_raw) begin
                        r_state       <= ST_GRANT;
                        r_grant       <= w_onehot;
                        r_grant_id    <= w_win;
                        r_grant_valid <= 1'b1;
                        r_last_id     <= w_win;
                        r_hold_cnt    <= '0;
                    end
                end
                ST_GRANT: begin
                    if (bus.done || !w_req_own || w_expire) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_hold_cnt    <= '0;
                        // Expiry only flags a timeout when it is the sole release cause.
                        r_timeout     <= w_expire && !bus.done && w_req_own;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HCW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_valid = r_grant_valid;
    assign bus.timeout     = r_timeout;
endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed bench for rr_priority_arbiter with hand-computed expected grants.
module tb_rr_priority_arbiter;
    import arb_pkg::*;

    logic clk;
    logic rst_n;
    int unsigned total;
    int unsigned bad;

    rr_priority_arbiter_if #(.N(8), .IDW(3)) bus ();

    rr_priority_arbiter #(.N(8), .IDW(3), .MAX_HOLD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the dead/idle cycle: expect a grant to exp_id, then release it with done.
    task automatic grant_cycle(input string tag, input logic [2:0] exp_id);
        tick();
        chk({tag, "_valid"}, 32'(bus.grant_valid), 32'd1);
        chk({tag, "_id"},    32'(bus.grant_id),    32'(exp_id));
        chk({tag, "_grant"}, 32'(bus.grant),       32'(arb_onehot(exp_id)));
        bus.done = 1'b1;
        tick();
        chk({tag, "_dead"},  32'(bus.grant),       32'd0);
        bus.done = 1'b0;
    endtask

    initial begin
        int unsigned n;
        logic [2:0]  rot [9];

        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        rot      = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};

        #12;
        chk("rst_grant",   32'(bus.grant),       32'd0);
        chk("rst_valid",   32'(bus.grant_valid), 32'd0);
        chk("rst_id",      32'(bus.grant_id),    32'd0);
        chk("rst_timeout", 32'(bus.timeout),     32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_noreq", 32'(bus.grant_valid), 32'd0);

        // Single requester 0, released by done.
        bus.req = 8'b0000_0001;
        tick();
        chk("t1_grant", 32'(bus.grant),       32'h01);
        chk("t1_id",    32'(bus.grant_id),    32'd0);
        chk("t1_valid", 32'(bus.grant_valid), 32'd1);
        bus.done = 1'b1;
        bus.req  = '0;
        tick();
        chk("t1_rel",   32'(bus.grant),       32'd0);
        chk("t1_relv",  32'(bus.grant_valid), 32'd0);
        bus.done = 1'b0;
        tick();

        // Two requesters at the extremes alternate.
        bus.req = 8'b1000_0001;
        grant_cycle("t2a", 3'd7);
        grant_cycle("t2b", 3'd0);
        grant_cycle("t2c", 3'd7);
        grant_cycle("t2d", 3'd0);

        // Full rotation with wrap.
        bus.req = 8'hFF;
        for (int i = 0; i < 9; i++)
            grant_cycle($sformatf("t3_%0d", i), rot[i]);

        // Lone requester 4 held to expiry.
        bus.req = 8'b0001_0000;
        tick();
        chk("t4_id", 32'(bus.grant_id), 32'd4);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.grant_valid) n++;
            else break;
        end
        chk("t4_hold",    n,                    32'd16);
        chk("t4_timeout", 32'(bus.timeout),     32'd1);
        chk("t4_relg",    32'(bus.grant),       32'd0);
        tick();
        chk("t4_regrant", 32'(bus.grant_id),    32'd4);
        chk("t4_valid",   32'(bus.grant_valid), 32'd1);
        chk("t4_to_clr",  32'(bus.timeout),     32'd0);

        // Owner 5 drops while requester 2 rises.
        bus.req = '0;
        tick();
        chk("t5_drop_to", 32'(bus.timeout), 32'd0);
        bus.req = 8'h20;
        tick();
        chk("t5_id5", 32'(bus.grant_id), 32'd5);
        bus.req = 8'h04;
        tick();
        chk("t5_dead",   32'(bus.grant),    32'd0);
        chk("t5_keepid", 32'(bus.grant_id), 32'd5);
        tick();
        chk("t5_id2",    32'(bus.grant_id), 32'd2);

        // done coinciding with expiry: no timeout pulse.
        for (int i = 0; i < 15; i++) tick();
        chk("t6_still", 32'(bus.grant_valid), 32'd1);
        bus.done = 1'b1;
        tick();
        chk("t6_rel",     32'(bus.grant_valid), 32'd0);
        chk("t6_notmout", 32'(bus.timeout),     32'd0);
        // done in IDLE must not block the grant.
        tick();
        chk("t6_idle_done", 32'(bus.grant_valid), 32'd1);
        bus.done = 1'b0;
        tick();

        // Async reset mid-grant.
        bus.req = '0;
        tick();
        bus.req = 8'h20;
        tick();
        chk("t7_grant", 32'(bus.grant), 32'h20);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_grant", 32'(bus.grant),       32'd0);
        chk("t7_rst_valid", 32'(bus.grant_valid), 32'd0);
        chk("t7_rst_to",    32'(bus.timeout),     32'd0);
        #2;
        rst_n   = 1'b1;
        bus.req = 8'h21;
        tick();
        chk("t7_after_id", 32'(bus.grant_id), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Sequential arbiter that shares one downstream resource (bus or datapath slot) among 8 requesters.
- Built around a highest-index-first priority encoder, wrapped in a rotating-priority scheme so that no requester starves.
- Grants are held until the owner releases or a hold timeout expires.
- Sits between requester blocks and the shared resource. Its registered grant_id drives the resource's select mux.

Parameters:
- N, 8, number of requesters; N must be a power of two and at least 2.
- IDW, 3, grant_id width; must equal log2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector; bit k high means requester k wants the resource.
- done  input  1  current owner signals release. Sampled only in GRANT state.
- grant  output  N  one-hot grant, registered; all zeros when no owner.
- grant_id  output  IDW  binary index of the owner, registered. Valid only while grant_valid=1.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (async assert, sync-safe deassert): grant=0, grant_id=0, grant_valid=0, timeout=0, state=IDLE, last_id=0, hold_cnt=0.
- States: IDLE, GRANT.
- Winner selection, combinational, evaluated in IDLE only:
  - masked = req with bits [N-1:last_id] cleared, i.e. only indices below last_id remain.
  - If masked is non-zero, the winner is the highest set bit of masked.
  - Otherwise the winner is the highest set bit of req.
  - Effect: priority rotates downward from the last owner and wraps from index 0 back to N-1.
- IDLE:
  - If req != 0, at the next edge: state=GRANT, grant=onehot(winner), grant_id=winner, grant_valid=1, last_id=winner, hold_cnt=0.
  - Latency from req to grant is 1 cycle.
  - If req == 0, remain in IDLE with all outputs 0.
- GRANT: release at the next edge if any of these holds in the current cycle:
  - done=1, or
  - req[grant_id]=0, or
  - hold_cnt == MAX_HOLD-1.
- Otherwise in GRANT: hold_cnt increments and the grant is unchanged.
- On release: state=IDLE, grant=0, grant_valid=0, hold_cnt=0. grant_id keeps its last value.
  - timeout=1 for that one cycle only when the release cause was expiry and neither done=1 nor req drop was present.
  - If done and expiry coincide, done wins and timeout stays 0.
- Mandatory dead cycle: after any release, grant=0 for exactly one cycle before the next grant, even if requests are pending. Minimum owner-to-owner gap is 1 cycle.
- Requests from non-owners during GRANT are ignored; there is no preemption.
- done while in IDLE is ignored.
- Single requester that re-requests continuously: it is re-granted after each dead cycle. A timeout never blocks it when no one else is requesting.
- last_id updates only when a grant is issued, never on release.
- Async reset mid-grant: all outputs clear immediately; after reset the next arbitration starts from last_id=0.
- Outputs are registered; there is no combinational path from req or done to any output.

Decomposition:
- Package arb_pkg:
  - constants ARB_N=8, ARB_IDW=3, ARB_MAX_HOLD=16.
  - state enum {ST_IDLE, ST_GRANT}.
  - onehot-from-index helper function.
- Sub-module prio_enc_n:
  - parameterized combinational encoder with inputs in[N-1:0] and outputs idx[IDW-1:0] and any.
  - highest set bit wins; idx=0 when any=0.
  - instantiated twice: once on masked requests, once on raw requests.

Test Plan:
- Reset then req=8'b0000_0001 → one cycle later grant=8'h01, grant_id=0, grant_valid=1. After done=1 for one cycle → grant=0 on the next cycle.
- req=8'b1000_0001 held, done pulsed each grant:
  - grants alternate id 7, 0, 7, 0.
  - each grant is separated by exactly one grant=0 cycle.
- req=8'hFF held, done pulsed after 1 grant cycle each time → grant_id sequence 7,6,5,4,3,2,1,0,7 (rotation with wrap).
- req=8'b0001_0000 held, done never asserted:
  - grant is held exactly 16 cycles.
  - timeout=1 on the release cycle, grant=0 on that same cycle, then re-grant id 4.
- While owner 5 is granted, req[5] drops and req[2] rises in the same cycle → release next edge, dead cycle, then grant_id=2.
- rst_n asserted low mid-grant while grant=8'h20 → grant=0, grant_valid=0, timeout=0 immediately, with no clock edge needed. After release with req=8'h21 → grant_id=5.
